// File: rtl/aes_round_ctrl_pkg.sv
// Shared encodings and sizing constants for the iterative AES-128 round sequencer.
package aes_pkg;

  localparam int AES_NR_128 = 10;
  localparam int RIDX_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/aes_lat_counter.sv
// Per-round cycle counter: counts 0..LAT-1 while enabled and flags the last cycle of a round.
module aes_lat_counter
  import aes_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [RIDX_W-1:0] cnt,
  output logic              tc
);

  localparam logic [RIDX_W-1:0] LAST = RIDX_W'(LAT - 1);

  logic [RIDX_W-1:0] cnt_r;

  assign cnt = cnt_r;
  assign tc  = en && (cnt_r == LAST);

  // Count register: wraps to zero at terminal count so each round starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {RIDX_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {RIDX_W{1'b0}};
    end else if (tc) begin
      cnt_r <= {RIDX_W{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + {{(RIDX_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer (IDLE -> ROUND x NR -> DONE).
// Optional abort input enabled by defining AES_ROUND_CTRL_ABORT_EN.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR        = AES_NR_128,
  parameter int ROUND_LAT = 1
) (
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic              abort,
`endif
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              dp_load,
  output logic              dp_round_en,
  output logic              dp_final,
  output logic              key_step,
  output logic [RIDX_W-1:0] round_idx,
  output logic              busy
);

  localparam logic [RIDX_W-1:0] NR_L = RIDX_W'(NR);
  localparam logic [RIDX_W-1:0] ONE  = RIDX_W'(1);

  state_t            state_r;
  state_t            state_nx;
  logic [RIDX_W-1:0] ridx_r;
  logic [RIDX_W-1:0] ridx_nx;
  logic              abort_s;
  logic              cnt_clr_s;
  logic              cnt_en_s;
  logic              cnt_tc_s;
  logic [RIDX_W-1:0] lat_cnt_s;

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  aes_lat_counter #(
    .LAT (ROUND_LAT)
  ) u_lat (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr_s),
    .en  (cnt_en_s),
    .cnt (lat_cnt_s),
    .tc  (cnt_tc_s)
  );

  assign round_idx = ridx_r;
  assign busy      = (state_r != IDLE);

  // State and round-index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      ridx_r  <= {RIDX_W{1'b0}};
    end else begin
      state_r <= state_nx;
      ridx_r  <= ridx_nx;
    end
  end

  // Next-state and datapath strobes; abort pre-empts both acceptance and round completion.
  always_comb begin
    state_nx    = state_r;
    ridx_nx     = ridx_r;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    dp_load     = 1'b0;
    dp_round_en = 1'b0;
    key_step    = 1'b0;
    dp_final    = 1'b0;
    cnt_clr_s   = 1'b1;
    cnt_en_s    = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        ridx_nx  = {RIDX_W{1'b0}};
        if (in_valid && !abort_s) begin
          dp_load  = 1'b1;
          state_nx = ROUND;
          ridx_nx  = ONE;
        end else begin
          state_nx = IDLE;
        end
      end
      ROUND: begin
        dp_final = (ridx_r == NR_L);
        if (abort_s) begin
          state_nx = IDLE;
          ridx_nx  = {RIDX_W{1'b0}};
        end else begin
          cnt_clr_s = 1'b0;
          cnt_en_s  = 1'b1;
          if (cnt_tc_s) begin
            dp_round_en = 1'b1;
            key_step    = 1'b1;
            if (ridx_r == NR_L) begin
              state_nx = DONE;
              ridx_nx  = {RIDX_W{1'b0}};
            end else begin
              ridx_nx = ridx_r + ONE;
            end
          end else begin
            ridx_nx = ridx_r;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        ridx_nx   = {RIDX_W{1'b0}};
        if (abort_s || out_ready) begin
          state_nx = IDLE;
        end else begin
          state_nx = DONE;
        end
      end
      default: begin
        state_nx = IDLE;
        ridx_nx  = {RIDX_W{1'b0}};
      end
    endcase
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Iterative AES-128 encryption sequencer. Drives the shared round datapath: sub_bytes -> shift_rows -> mix_columns -> add_round_key, plus the round-key expander.
- Accepts one block through a valid/ready handshake and times the registered datapath stages over NR rounds.
- Flags the final round so mix_columns is bypassed, then presents the result through an output valid/ready handshake.
- Holds no data path itself. Sits between the top-level AES wrapper and the round datapath.

Parameters:
- NR, 10, number of rounds (AES-128); legal range 1..15.
- ROUND_LAT, 1, clock cycles the datapath needs per round (registered stages); legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  plaintext and key present at the datapath inputs
- in_ready  output  1  controller can accept a block
- out_valid  output  1  ciphertext valid at the datapath output
- out_ready  input  1  consumer accepts the ciphertext
- dp_load  output  1  1-cycle pulse: datapath loads plaintext XOR key0; expander loads the key
- dp_round_en  output  1  1-cycle pulse: datapath state register captures the round result
- dp_final  output  1  current round is round NR; mix_columns bypassed
- key_step  output  1  1-cycle pulse: expander advances to the next round key (coincident with dp_round_en)
- round_idx  output  4  current round 1..NR; 0 when not in ROUND
- busy  output  1  high in ROUND and DONE

Behaviour:
- Reset values (async, while rst=1): state=IDLE, round_idx=0, lat_cnt=0. Outputs: in_ready=1, all other outputs 0. Reset mid-operation discards the block with no residual pulse.
- States: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - If in_valid: dp_load=1 in that cycle; next state=ROUND, round_idx=1, lat_cnt=0.
- ROUND:
  - in_ready=0. lat_cnt increments each cycle.
  - When lat_cnt==ROUND_LAT-1: dp_round_en=1 and key_step=1 (combinational, same cycle), and lat_cnt returns to 0.
    - If round_idx==NR: next state=DONE.
    - Otherwise: round_idx increments.
  - dp_final = (state==ROUND && round_idx==NR).
- DONE:
  - out_valid=1, round_idx=0. out_valid holds until out_ready.
  - On out_valid && out_ready: next state=IDLE.
  - No new block is accepted in DONE; in_ready=0.
- Latency: acceptance cycle T (dp_load) to first out_valid = NR*ROUND_LAT+1 cycles. Default: 11 cycles.
- Throughput: one block per NR*ROUND_LAT+2 cycles when out_ready is held high.
- in_valid during ROUND or DONE is ignored; in_valid is not required to be held.
- out_ready while not in DONE has no effect.
- lat_cnt width is 4 bits; round_idx saturation is never reached because NR<=15.

Optional Feature:
- Macro: AES_ROUND_CTRL_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit).
  - abort=1 in ROUND or DONE forces next state=IDLE and round_idx=0, suppressing any dp_round_en/key_step in that cycle.
  - abort takes priority over completion.
  - abort in IDLE is ignored, and abort has priority over a simultaneous in_valid (no dp_load).
- When undefined: no abort port; behaviour exactly as above.

Decomposition:
- Package aes_pkg:
  - state encoding constants (IDLE=2'd0, ROUND=2'd1, DONE=2'd2)
  - AES_NR_128=10
  - round-index width constant (4)
- Sub-module aes_lat_counter:
  - ROUND_LAT-bounded cycle counter with a terminal-count output.
  - Instantiated once; clear and enable are driven by the FSM.

Test Plan:
- Reset: rst=1 for 100 ns then 0. Required: in_ready=1, busy=0, round_idx=0, all pulses 0 throughout.
- Nominal (NR=10, ROUND_LAT=1), in_valid for one cycle at T0, out_ready=1. Required:
  - dp_load at T0
  - dp_round_en/key_step at T1..T10, round_idx 1..10
  - dp_final only at T10
  - out_valid at T11; in_ready=1 at T12
- Backpressure: out_ready=0 for 5 cycles after out_valid rises. Required: out_valid stays high, no extra dp_round_en, in_ready=0. Drop to IDLE the cycle after out_ready=1.
- ROUND_LAT=3, NR=10. Required: dp_round_en every 3rd cycle (T3, T6, ..., T30), exactly 10 pulses, out_valid at T31. in_valid asserted at T5 is ignored (no dp_load).
- Reset mid-run: rst asserted at T4 of the nominal run. Required: immediate return to in_ready=1, round_idx=0, no dp_round_en after rst rises. A new block after release completes normally in 11 cycles.
- AES_ROUND_CTRL_ABORT_EN: abort at T6 with in_valid=1. Required: no dp_round_en at T6, IDLE at T7, in_ready=1. A second block accepted at T7 yields out_valid at T18.
